// File: rtl/sum_accumulator.sv
// sum_accumulator: collects COUNT unsigned operands per frame into a
// WIDTH-bit modular sum with a sticky carry-out flag, then holds the result
// until the consumer takes it.
module sum_accumulator #(
    parameter int WIDTH = 5,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             ovf
);

    // Counter must be able to represent COUNT itself (up to 255).
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [WIDTH:0]     add_full;
    logic               accept;

    // Handshake flags depend on state only, so no input-to-output path exists.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // One extra bit captures the carry-out of the running add.
    assign add_full  = {1'b0, sum_q} + {1'b0, in_data};
    assign cnt_inc   = cnt_q + CNT_ONE;

    assign sum_out   = sum_q;
    assign ovf       = ovf_q;

    // Next-state and datapath update; clr overrides every other input.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = IDLE;
            sum_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // First operand of a frame replaces the previous result.
                    if (accept) begin
                        sum_d   = in_data;
                        ovf_d   = 1'b0;
                        cnt_d   = CNT_ONE;
                        state_d = (COUNT == 1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        sum_d = add_full[WIDTH-1:0];
                        ovf_d = ovf_q | add_full[WIDTH];
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Result stays visible after hand-off until the next frame starts.
                    if (out_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 5: operand and sum width in bits.
REQ-002 SHALL have parameter COUNT, default 4: operands per frame, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clr, input, 1 bit: synchronous frame abort, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 SHALL have port in_data, input, WIDTH bits: unsigned operand.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-009 SHALL have port out_valid, output, 1 bit: frame result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-011 SHALL have port sum_out, output, WIDTH bits: frame sum modulo 2^WIDTH.
REQ-012 SHALL have port ovf, output, 1 bit: sticky carry-out seen during frame.

Function
REQ-013 SHALL count an operand accepted on a rising edge with in_valid=1 and in_ready=1, and only then.
REQ-014 SHALL implement states IDLE, ACC and HOLD; in_ready SHALL be 1 in IDLE/ACC and 0 in HOLD, decoded from state only.
REQ-015 IDLE, on accept: sum <= in_data, ovf <= 0, cnt <= 1; go to HOLD if COUNT==1, else ACC.
REQ-016 ACC, on accept: sum <= (sum + in_data) mod 2^WIDTH; ovf <= ovf OR carry-out of that add; cnt <= cnt+1; go to HOLD when new cnt equals COUNT.
REQ-017 IDLE/ACC, no accept: hold sum, ovf, cnt and state, for any number of idle cycles.
REQ-018 out_valid SHALL be 1 exactly in HOLD; it SHALL rise the cycle after the COUNT-th accept (latency 1 clock).
REQ-019 HOLD: sum_out, ovf SHALL stay stable; in_data/in_valid ignored.
REQ-020 HOLD, out_ready=1 at an edge: go to IDLE; cnt <= 0; sum_out and ovf keep the frame value until the next frame's first accept.
REQ-021 out_ready outside HOLD SHALL have no effect.
REQ-022 clr=1 at an edge SHALL override all other inputs in any state: state <= IDLE, cnt <= 0, sum <= 0, ovf <= 0; no operand accepted that cycle.
REQ-023 cnt SHALL be wide enough to hold COUNT and SHALL never exceed COUNT.
REQ-024 sum_out SHALL be the sum register directly (no combinational path from in_data).

Reset
REQ-025 reset=0 SHALL force, without a clock edge: state=IDLE, cnt=0, sum_out=0, ovf=0, out_valid=0; hence in_ready=1.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first accept after release starts a new frame per REQ-015.
REQ-027 Reset SHALL dominate clr and all handshake inputs.

Verification (WIDTH=5, COUNT=4)
REQ-028 Back-to-back 3,4,5,6 with out_ready=1 -> out_valid for one cycle, starting the cycle after the 6 is accepted; sum_out=18, ovf=0.
REQ-029 Operands 20,15,1,0 -> sum_out=4, ovf=1.
REQ-030 Gapped stream 1, 3 idle cycles, 2,3,4 -> sum_out=10 at the same latency after the last accept.
REQ-031 out_ready=0 for 5 cycles in HOLD with in_valid=1, in_data=7 -> in_ready=0, sum_out constant; after out_ready=1 the next frame 1,1,1,1 -> sum_out=4 (7 never accepted).
REQ-032 clr after 2 accepts (9,9) -> IDLE, sum_out=0; next 2,2,2,2 -> sum_out=8, ovf=0.
REQ-033 reset low between clock edges mid-frame -> sum_out=0, out_valid=0, ovf=0 immediately; after release 5,5,5,5 -> sum_out=20.
